alu_issue_ctrl: RTL

// Issuing end of the ALU en/valid interface: accepts one decoded-register RV32I ALU instruction,

---
 rtl/alu_issue_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded RV32I ALU instruction per step to an en/valid ALU; shifts run as single-bit steps.
// Latency: non-shift transfer->wb_valid 3 cycles, shift by N 1+2N cycles; one instruction in flight.
// Backpressure: instr_ready only in IDLE; wb held until wb_ready. Define ALU_ISSUE_MULDIV_EN for MUL/DIV/REM.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             alu_en,
    output logic [WIDTH-1:0] alu_port_A,
    output logic [WIDTH-1:0] alu_port_B,
    output logic [OPW-1:0]   alu_operation,
    input  logic [WIDTH-1:0] alu_data_out,
    input  logic             alu_valid,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             illegal
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    localparam logic [OPW-1:0] OP_ADD = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_SUB = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SLL = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_XOR = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_SRL = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_SRA = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_OR  = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_AND = OPW'(5'b01010);
`ifdef ALU_ISSUE_MULDIV_EN
    localparam logic [OPW-1:0] OP_MUL = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_DIV = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_REM = OPW'(5'b01001);
`endif

    logic [1:0]       state;
    logic [4:0]       count;
    logic             is_shift;

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             dec_ill;
    logic             dec_shift;
    logic             dec_imm;
    logic [OPW-1:0]   dec_op;
    logic [4:0]       dec_shamt;
    logic [WIDTH-1:0] imm_sx;
    logic             unused_rs1_field;

    assign opcode           = instr[6:0];
    assign f3               = instr[14:12];
    assign f7               = instr[31:25];
    assign imm_sx           = {{(WIDTH-12){instr[31]}}, instr[31:20]};
    assign unused_rs1_field = ^instr[19:15];

    assign instr_ready = (state == S_IDLE) && !rst;
    assign alu_en      = (state == S_ISSUE);
    assign wb_valid    = (state == S_WB);

    always_comb begin
        dec_ill   = 1'b1;
        dec_shift = 1'b0;
        dec_imm   = 1'b0;
        dec_op    = '0;
        dec_shamt = rs2_data[4:0];
        if (opcode == 7'b0110011) begin
            case (f7)
                7'b0000000: begin
                    dec_ill = 1'b0;
                    case (f3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  begin dec_op = OP_SLL; dec_shift = 1'b1; end
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  begin dec_op = OP_SRL; dec_shift = 1'b1; end
                        3'b110:  dec_op = OP_OR;
                        3'b111:  dec_op = OP_AND;
                        default: dec_ill = 1'b1;
                    endcase
                end
                7'b0100000: begin
                    if (f3 == 3'b000) begin
                        dec_ill = 1'b0;
                        dec_op  = OP_SUB;
                    end else if (f3 == 3'b101) begin
                        dec_ill   = 1'b0;
                        dec_op    = OP_SRA;
                        dec_shift = 1'b1;
                    end
                end
`ifdef ALU_ISSUE_MULDIV_EN
                7'b0000001: begin
                    dec_ill = 1'b0;
                    case (f3)
                        3'b000:  dec_op = OP_MUL;
                        3'b100:  dec_op = OP_DIV;
                        3'b110:  dec_op = OP_REM;
                        default: dec_ill = 1'b1;
                    endcase
                end
`endif
                default: dec_ill = 1'b1;
            endcase
        end else if (opcode == 7'b0010011) begin
            dec_imm   = 1'b1;
            dec_shamt = instr[24:20];
            dec_ill   = 1'b0;
            case (f3)
                3'b000: dec_op = OP_ADD;
                3'b100: dec_op = OP_XOR;
                3'b110: dec_op = OP_OR;
                3'b111: dec_op = OP_AND;
                3'b001: begin
                    dec_op    = OP_SLL;
                    dec_shift = 1'b1;
                    dec_ill   = (f7 != 7'b0000000);
                end
                3'b101: begin
                    dec_op    = (f7 == 7'b0100000) ? OP_SRA : OP_SRL;
                    dec_shift = 1'b1;
                    dec_ill   = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
                default: dec_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            count         <= '0;
            is_shift      <= 1'b0;
            alu_port_A    <= '0;
            alu_port_B    <= '0;
            alu_operation <= '0;
            wb_rd         <= '0;
            wb_data       <= '0;
            illegal       <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        wb_rd <= instr[11:7];
                        if (dec_ill) begin
                            illegal <= 1'b1;
                        end else if (dec_shift && dec_shamt == 5'd0) begin
                            wb_data <= rs1_data;
                            state   <= S_WB;
                        end else begin
                            // Shifts are issued as repeated shift-by-one steps.
                            alu_port_A    <= rs1_data;
                            alu_port_B    <= dec_shift ? WIDTH'(1) : (dec_imm ? imm_sx : rs2_data);
                            alu_operation <= dec_op;
                            count         <= dec_shamt;
                            is_shift      <= dec_shift;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (alu_valid) begin
                        wb_data <= alu_data_out;
                        if (is_shift && count != 5'd1) begin
                            alu_port_A <= alu_data_out;
                            count      <= count - 5'd1;
                            state      <= S_ISSUE;
                        end else begin
                            state <= S_WB;
                        end
                    end
                end
                default: begin
                    if (wb_ready) state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
